// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive sink.
// Holds the receiver FSM state encoding and the baud-tick divisor calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Clocks per oversample tick; never below 1 so a tick always exists.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO for received characters.
// Pointers carry one extra wrap bit so full and empty can be told apart.
// A pop while full frees the slot the simultaneous push writes into.
module uart_rx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [7:0]         push_data,
  input  logic               pop,
  output logic [7:0]         rd_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
                   (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage: each entry loads the pushed byte when the write pointer selects it.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      assign mem_d[gi] = (do_push && (wr_ptr_q[FIFO_AW-1:0] == FIFO_AW'(gi))) ?
                         push_data : mem_q[gi];
      // Entry register, cleared so the head reads 0 out of reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q[gi] <= '0;
        else     mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_rx_sink.sv
// uart_rx_sink: 8N1 UART receiver with 16x oversampling, FWFT byte FIFO and
// sticky overflow/framing error flags. Defining UART_RX_PARITY_EN adds an
// even-parity bit after the data bits and a sticky parity_err output.
module uart_rx_sink
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               overflow,
  output logic               frame_err,
`ifdef UART_RX_PARITY_EN
  output logic               parity_err,
`endif
  input  logic               err_clr
);

  localparam int DIV = calc_div(SYS_CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);

  logic [1:0]    sync_q, sync_d;
  logic          rx_s;
  logic          rx_prev_q, rx_prev_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick;
  logic          start_edge;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          frame_err_set;
  logic          overflow_set;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          parity_err_set;
  logic          parity_err_q, parity_err_d;
`endif

  assign rx_s       = sync_q[1];
  assign tick       = (div_cnt_q == DW'(DIV - 1));
  assign start_edge = (state_q == IDLE) && rx_prev_q && !rx_s;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_comb begin
    sync_d    = {sync_q[0], rx};
    rx_prev_d = rx_s;
  end

  // Synchronizer registers idle high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  // Free-running oversample divider, realigned to each detected start edge.
  always_comb begin
    if (start_edge || tick) div_cnt_d = '0;
    else                    div_cnt_d = div_cnt_q + 1'b1;
  end

  // Divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

  // Receiver FSM next-state: samples mid-bit by counting oversample ticks.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    push_d        = 1'b0;
    frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d      = par_bad_q;
    parity_err_set = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == TW'(OVERSAMPLE / 2 - 1)) begin
            tick_cnt_d = '0;
            bit_idx_d  = 3'd0;
            state_d    = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            par_bad_d  = 1'b0;
`endif
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == TW'(OVERSAMPLE - 1)) begin
            tick_cnt_d         = '0;
            shift_d[bit_idx_q] = rx_s;
            bit_idx_d          = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tick_cnt_q == TW'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            state_d    = STOP;
            if ((^shift_q) ^ rx_s) begin
              par_bad_d      = 1'b1;
              parity_err_set = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == TW'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              push_d = !par_bad_q;
`else
              push_d = 1'b1;
`endif
              state_d = IDLE;
            end else begin
              frame_err_set = 1'b1;
              state_d       = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver FSM registers, including the registered push request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  // A push into a full FIFO is lost unless a pop frees a slot that same cycle.
  assign overflow_set = push_q && full && !rd_en;

  // Sticky flags: a new error outranks a simultaneous clear.
  always_comb begin
    frame_err_d = frame_err_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
    overflow_d  = overflow_set  ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_set ? 1'b1 : (err_clr ? 1'b0 : parity_err_q);
`endif
  end

  // Sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

  uart_rx_fifo #(
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

endmodule

// File: tb/tb_uart_rx_sink.sv
// Directed bench for uart_rx_sink with a divisor of 1 (one tick per clock),
// 16x oversampling and a 4-entry FIFO. Each bit lasts 16 clocks.
module tb_uart_rx_sink;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_rx_sink #(
    .SYS_CLK_FREQ (1843200),
    .BAUD_RATE    (115200),
    .OVERSAMPLE   (16),
    .FIFO_AW      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .err_clr   (err_clr)
  );

  // Drive one 160-clock frame; rx is left at the stop-bit level afterwards.
  // empty is captured 154 and 155 clocks after the start bit (stop sample
  // edge and the following edge); rd_en is held for the one cycle after
  // clock pop_at when pop_at >= 0.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int pop_at, output logic e154, output logic e155);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    e154 = 1'bx;
    e155 = 1'bx;
    for (int n = 0; n < 160; n++) begin
      rx = bits[n / 16];
      @(posedge clk); #1;
      rd_en = (n == pop_at);
      if (n == 154) e154 = empty;
      if (n == 155) e155 = empty;
    end
    rd_en = 1'b0;
    $display("[TB] sent frame 0x%02h stop=%0d count=%0d", data, stop_bit, count);
  endtask

  task automatic pop_one;
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", empty); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", full); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    rst = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL idle_empty: got %b expected 1", empty); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL idle_count: got %0d expected 0", count); end
    $display("[TB] reset and idle line done");
  endtask

  task automatic test_single_frame;
    logic e154, e155;
    send_frame(8'h41, 1'b1, -1, e154, e155);
    tests_run++; if (e154 !== 1'b1) begin tests_failed++; $display("FAIL latency_at_sample: empty=%b expected 1", e154); end
    tests_run++; if (e155 !== 1'b0) begin tests_failed++; $display("FAIL latency_after_sample: empty=%b expected 0", e155); end
    tests_run++; if (rd_data !== 8'h41) begin tests_failed++; $display("FAIL single_rd_data: got %h expected 41", rd_data); end
    tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", count); end
    pop_one();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL single_pop_empty: got %b expected 1", empty); end
    $display("[TB] single frame 0x41 done");
  endtask

  task automatic test_glitch;
    logic e154, e155;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL glitch_count: got %0d expected 0", count); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL glitch_frame_err: got %b expected 0", frame_err); end
    send_frame(8'h5A, 1'b1, -1, e154, e155);
    tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL glitch_next_count: got %0d expected 1", count); end
    tests_run++; if (rd_data !== 8'h5A) begin tests_failed++; $display("FAIL glitch_next_data: got %h expected 5a", rd_data); end
    pop_one();
    $display("[TB] glitch rejected, frame 0x5A done");
  endtask

  task automatic test_framing_error;
    logic e154, e155;
    send_frame(8'h55, 1'b0, -1, e154, e155);
    rx = 1'b0;
    repeat (40 * 16) @(posedge clk);
    #1;
    tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL frame_err_set: got %b expected 1", frame_err); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL frame_err_no_push: got %0d expected 0", count); end
    rx = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL break_no_retrigger: got %0d expected 0", count); end
    send_frame(8'h0A, 1'b1, -1, e154, e155);
    tests_run++; if (count !== 3'd1) begin tests_failed++; $display("FAIL after_break_count: got %0d expected 1", count); end
    tests_run++; if (rd_data !== 8'h0A) begin tests_failed++; $display("FAIL after_break_data: got %h expected 0a", rd_data); end
    tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL frame_err_sticky: got %b expected 1", frame_err); end
    pop_one();
    pulse_clr();
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL frame_err_clear: got %b expected 0", frame_err); end
    $display("[TB] framing error and recovery done");
  endtask

  task automatic test_overflow;
    logic e154, e155;
    logic [7:0] exp;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, e154, e155);
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full: got %b expected 1", full); end
    tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count: got %0d expected 4", count); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      tests_run++; if (rd_data !== exp) begin tests_failed++; $display("FAIL ovf_read%0d: got %h expected %h", i, rd_data, exp); end
      pop_one();
    end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL ovf_drained: got %b expected 1", empty); end
    pulse_clr();
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    $display("[TB] overflow done");
  endtask

  task automatic test_full_pop;
    logic e154, e155;
    logic [7:0] exp;
    for (int i = 2; i <= 5; i++) send_frame(8'(i), 1'b1, -1, e154, e155);
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL fullpop_prefill: got %b expected 1", full); end
    send_frame(8'h06, 1'b1, 154, e154, e155);
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
    tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL fullpop_count: got %0d expected 4", count); end
    for (int i = 3; i <= 6; i++) begin
      exp = 8'(i);
      tests_run++; if (rd_data !== exp) begin tests_failed++; $display("FAIL fullpop_read%0d: got %h expected %h", i, rd_data, exp); end
      pop_one();
    end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL fullpop_drained: got %b expected 1", empty); end
    $display("[TB] full with simultaneous pop done");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_framing_error();
    test_overflow();
    test_full_pop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
